// File: rtl/sdram_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sdram_cmd_pkg
// Brief   : SDRAM command encodings, init-check error codes and FSM states,
//           shared by the init, controller and checker blocks.
// Revision: 1.0  initial release
// ============================================================================
package sdram_cmd_pkg;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_MSET = 4'b0000;
    // cs_n=1 never survives decode, so this pattern is free to tag illegal opcodes
    localparam logic [3:0] CMD_ILL  = 4'b1000;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_EARLY   = 3'd1;
    localparam logic [2:0] ERR_PRE_A10 = 3'd2;
    localparam logic [2:0] ERR_TIMING  = 3'd3;
    localparam logic [2:0] ERR_ORDER   = 3'd4;
    localparam logic [2:0] ERR_MODE    = 3'd5;

    localparam logic [2:0] ST_PWR_WAIT  = 3'd0;
    localparam logic [2:0] ST_WAIT_PRE  = 3'd1;
    localparam logic [2:0] ST_WAIT_AREF = 3'd2;
    localparam logic [2:0] ST_WAIT_MSET = 3'd3;
    localparam logic [2:0] ST_MRD_WAIT  = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;
    localparam logic [2:0] ST_ERR       = 3'd6;

    function automatic logic [3:0] cmd_decode(input logic [3:0] cmd);
        logic [3:0] v;
        if (cmd[3]) begin
            v = CMD_NOP;
        end else begin
            case (cmd)
                CMD_PRE, CMD_AREF, CMD_MSET, CMD_NOP: v = cmd;
                default:                              v = CMD_ILL;
            endcase
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_gap_timer.sv
`default_nettype none
// ============================================================================
// Module  : sdram_gap_timer
// Brief   : Loadable down-counter; load wins over decrement, busy = non-zero.
// Revision: 1.0  initial release
// ============================================================================
module sdram_gap_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_busy
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_busy = (r_cnt != '0);

endmodule
`default_nettype wire

// File: rtl/sdram_init_chk.sv
`default_nettype none
// ============================================================================
// Module  : sdram_init_chk
// Brief   : Passive checker of the SDRAM power-up init command sequence.
// Revision: 1.0  initial release
// ============================================================================
module sdram_init_chk
    import sdram_cmd_pkg::*;
#(
    parameter int          DELAY_200US = 10000,
    parameter int          T_RP        = 1,
    parameter int          T_RC        = 4,
    parameter int          T_MRD       = 2,
    parameter int          AREF_MIN    = 2,
    parameter logic [11:0] MODE_VAL    = 12'h032
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [3:0]  cmd_reg,
    input  logic [11:0] sdram_addr,
    output logic        init_done,
    output logic        init_err,
    output logic [2:0]  err_code,
    output logic [3:0]  aref_cnt
);

    localparam logic [13:0] c_delay    = 14'(DELAY_200US);
    localparam logic [3:0]  c_aref_min = 4'(AREF_MIN);
    // Timer holds T-1 so that the command T edges later sees it at zero
    localparam logic [3:0]  c_t_rp     = 4'(T_RP - 1);
    localparam logic [3:0]  c_t_rc     = 4'(T_RC - 1);
    localparam logic [3:0]  c_t_mrd    = 4'(T_MRD - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [13:0] r_nop_cnt;
    logic [13:0] w_nop_cnt_nxt;
    logic [3:0]  r_aref_cnt;
    logic [3:0]  w_aref_nxt;
    logic        r_init_done;
    logic        r_init_err;
    logic [2:0]  r_err_code;
    logic [2:0]  w_err_nxt;
    logic [3:0]  w_cmd;
    logic        w_is_nop;
    logic        w_tmr_load;
    logic [3:0]  w_tmr_val;
    logic        w_tmr_busy;

    sdram_gap_timer #(
        .WIDTH (4)
    ) u_gap_timer (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_busy     (w_tmr_busy)
    );

    assign w_cmd    = cmd_decode(cmd_reg);
    assign w_is_nop = (w_cmd == CMD_NOP);

    always_comb begin
        w_state_nxt   = r_state;
        w_nop_cnt_nxt = r_nop_cnt;
        w_aref_nxt    = r_aref_cnt;
        w_err_nxt     = ERR_NONE;
        w_tmr_load    = 1'b0;
        w_tmr_val     = '0;

        case (r_state)
            ST_PWR_WAIT: begin
                if (!w_is_nop) begin
                    w_err_nxt = ERR_EARLY;
                end else if (r_nop_cnt >= c_delay - 14'd1) begin
                    w_nop_cnt_nxt = c_delay;
                    w_state_nxt   = ST_WAIT_PRE;
                end else begin
                    w_nop_cnt_nxt = r_nop_cnt + 14'd1;
                end
            end

            ST_WAIT_PRE: begin
                if (!w_is_nop) begin
                    if (w_tmr_busy) begin
                        w_err_nxt = ERR_TIMING;
                    end else if (w_cmd == CMD_PRE) begin
                        if (sdram_addr[10]) begin
                            w_tmr_load  = 1'b1;
                            w_tmr_val   = c_t_rp;
                            w_state_nxt = ST_WAIT_AREF;
                        end else begin
                            w_err_nxt = ERR_PRE_A10;
                        end
                    end else begin
                        w_err_nxt = ERR_ORDER;
                    end
                end
            end

            // WAIT_MSET only marks that enough refreshes have been seen
            ST_WAIT_AREF, ST_WAIT_MSET: begin
                if (!w_is_nop) begin
                    if (w_tmr_busy) begin
                        w_err_nxt = ERR_TIMING;
                    end else begin
                        case (w_cmd)
                            CMD_AREF: begin
                                if (r_aref_cnt != 4'hF) begin
                                    w_aref_nxt = r_aref_cnt + 4'd1;
                                end
                                w_tmr_load  = 1'b1;
                                w_tmr_val   = c_t_rc;
                                w_state_nxt = (w_aref_nxt >= c_aref_min) ? ST_WAIT_MSET
                                                                          : ST_WAIT_AREF;
                            end
                            CMD_PRE: begin
                                if (!sdram_addr[10]) begin
                                    w_err_nxt = ERR_PRE_A10;
                                end else if (r_aref_cnt == 4'd0) begin
                                    w_tmr_load = 1'b1;
                                    w_tmr_val  = c_t_rp;
                                end else begin
                                    w_err_nxt = ERR_ORDER;
                                end
                            end
                            CMD_MSET: begin
                                if (r_aref_cnt < c_aref_min) begin
                                    w_err_nxt = ERR_ORDER;
                                end else if (sdram_addr != MODE_VAL) begin
                                    w_err_nxt = ERR_MODE;
                                end else begin
                                    w_tmr_load  = 1'b1;
                                    w_tmr_val   = c_t_mrd;
                                    w_state_nxt = ST_MRD_WAIT;
                                end
                            end
                            default: w_err_nxt = ERR_ORDER;
                        endcase
                    end
                end
            end

            ST_MRD_WAIT: begin
                if (!w_tmr_busy) begin
                    w_state_nxt = ST_DONE;
                end else if (!w_is_nop) begin
                    w_err_nxt = ERR_TIMING;
                end
            end

            default: ;
        endcase

        if (w_err_nxt != ERR_NONE) begin
            w_state_nxt = ST_ERR;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state     <= ST_PWR_WAIT;
            r_nop_cnt   <= '0;
            r_aref_cnt  <= '0;
            r_init_done <= 1'b0;
            r_init_err  <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_state    <= w_state_nxt;
            r_nop_cnt  <= w_nop_cnt_nxt;
            r_aref_cnt <= w_aref_nxt;
            if (w_err_nxt != ERR_NONE) begin
                r_init_err <= 1'b1;
                r_err_code <= w_err_nxt;
            end
            if (w_state_nxt == ST_DONE) begin
                r_init_done <= 1'b1;
            end
        end
    end

    assign init_done = r_init_done;
    assign init_err  = r_init_err;
    assign err_code  = r_err_code;
    assign aref_cnt  = r_aref_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sdram_init_chk.sv
`default_nettype none
// ============================================================================
// Module  : tb_sdram_init_chk
// Brief   : Directed self-checking bench for sdram_init_chk.
// Revision: 1.0  initial release
// ============================================================================
module tb_sdram_init_chk;

    localparam logic [3:0] c_nop  = 4'b0111;
    localparam logic [3:0] c_pre  = 4'b0010;
    localparam logic [3:0] c_aref = 4'b0001;
    localparam logic [3:0] c_mset = 4'b0000;
    localparam logic [3:0] c_act  = 4'b0011;

    typedef struct {
        string      tag;
        logic       done;
        logic       err;
        logic [2:0] code;
        logic [3:0] aref;
    } exp_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [3:0]  cmd_reg = 4'b0111;
    logic [11:0] sdram_addr = '0;
    logic        init_done;
    logic        init_err;
    logic [2:0]  err_code;
    logic [3:0]  aref_cnt;

    exp_t sb_q[$];
    int   n_asserts = 0;
    int   n_fail    = 0;

    sdram_init_chk dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .cmd_reg    (cmd_reg),
        .sdram_addr (sdram_addr),
        .init_done  (init_done),
        .init_err   (init_err),
        .err_code   (err_code),
        .aref_cnt   (aref_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic expect_out(input string tag, input logic d, input logic e,
                              input logic [2:0] c, input logic [3:0] a);
        exp_t x;
        x.tag = tag; x.done = d; x.err = e; x.code = c; x.aref = a;
        sb_q.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        n_asserts++;
        assert (sb_q.size() != 0) else begin
            n_fail++;
            $error("FAIL scoreboard: observed empty queue, expected an entry");
        end
        if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            n_asserts += 4;
            assert (init_done === x.done) else begin
                n_fail++;
                $error("FAIL %s init_done: observed %0b expected %0b", x.tag, init_done, x.done);
            end
            assert (init_err === x.err) else begin
                n_fail++;
                $error("FAIL %s init_err: observed %0b expected %0b", x.tag, init_err, x.err);
            end
            assert (err_code === x.code) else begin
                n_fail++;
                $error("FAIL %s err_code: observed %0d expected %0d", x.tag, err_code, x.code);
            end
            assert (aref_cnt === x.aref) else begin
                n_fail++;
                $error("FAIL %s aref_cnt: observed %0d expected %0d", x.tag, aref_cnt, x.aref);
            end
        end
    endtask

    // Drive one command for one rising edge, then sample 1 time unit later
    task automatic step(input logic [3:0] cmd, input logic [11:0] addr);
        cmd_reg    = cmd;
        sdram_addr = addr;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic step_chk(input logic [3:0] cmd, input logic [11:0] addr, input string tag,
                            input logic d, input logic e, input logic [2:0] c, input logic [3:0] a);
        cmd_reg    = cmd;
        sdram_addr = addr;
        expect_out(tag, d, e, c, a);
        @(posedge sys_clk);
        #1;
        check_out();
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(c_nop, 12'h000);
    endtask

    task automatic do_reset(input string tag);
        cmd_reg    = c_nop;
        sdram_addr = 12'h000;
        sys_rst    = 1'b1;
        #1;
        expect_out(tag, 1'b0, 1'b0, 3'd0, 4'd0);
        check_out();
        @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
    endtask

    initial begin
        #2;
        do_reset("reset");

        // Sequence interrupted by reset after the first AREF, then a golden run
        nops(10000);
        step_chk(c_pre,  12'h400, "pre_ok",   1'b0, 1'b0, 3'd0, 4'd0);
        step_chk(c_aref, 12'h000, "aref1",    1'b0, 1'b0, 3'd0, 4'd1);
        do_reset("mid_reset");

        nops(10000);
        step_chk(c_pre,  12'h400, "g_pre",    1'b0, 1'b0, 3'd0, 4'd0);
        step_chk(c_aref, 12'h000, "g_aref1",  1'b0, 1'b0, 3'd0, 4'd1);
        nops(3);
        step_chk(c_aref, 12'h000, "g_aref2",  1'b0, 1'b0, 3'd0, 4'd2);
        nops(3);
        step_chk(c_mset, 12'h032, "g_mset",   1'b0, 1'b0, 3'd0, 4'd2);
        step_chk(c_nop,  12'h000, "g_mrd1",   1'b0, 1'b0, 3'd0, 4'd2);
        step_chk(c_nop,  12'h000, "g_done",   1'b1, 1'b0, 3'd0, 4'd2);
        step_chk(c_act,  12'h000, "g_ignore", 1'b1, 1'b0, 3'd0, 4'd2);
        step_chk(c_pre,  12'h000, "g_sticky", 1'b1, 1'b0, 3'd0, 4'd2);

        // Early command after 9999 NOPs
        do_reset("rst_early");
        nops(9999);
        step_chk(c_pre,  12'h400, "early",    1'b0, 1'b1, 3'd1, 4'd0);
        nops(100);
        expect_out("early_hold", 1'b0, 1'b1, 3'd1, 4'd0);
        check_out();

        // PRE without A10
        do_reset("rst_a10");
        nops(10000);
        step_chk(c_pre,  12'h000, "pre_a10",  1'b0, 1'b1, 3'd2, 4'd0);

        // AREF to AREF distance 2 < tRC
        do_reset("rst_trc");
        nops(10000);
        step(c_pre, 12'h400);
        step_chk(c_aref, 12'h000, "trc_aref1", 1'b0, 1'b0, 3'd0, 4'd1);
        step(c_nop, 12'h000);
        step_chk(c_aref, 12'h000, "trc_viol",  1'b0, 1'b1, 3'd3, 4'd1);

        // MSET after one AREF only
        do_reset("rst_order");
        nops(10000);
        step(c_pre, 12'h400);
        step(c_aref, 12'h000);
        nops(3);
        step_chk(c_mset, 12'h032, "order",    1'b0, 1'b1, 3'd4, 4'd1);

        // Wrong mode word, then further violations must not change the code
        do_reset("rst_mode");
        nops(10000);
        step(c_pre, 12'h400);
        step(c_aref, 12'h000);
        nops(3);
        step(c_aref, 12'h000);
        nops(3);
        step_chk(c_mset, 12'h033, "mode",     1'b0, 1'b1, 3'd5, 4'd2);
        step_chk(c_pre,  12'h000, "second1",  1'b0, 1'b1, 3'd5, 4'd2);
        step_chk(c_act,  12'h000, "second2",  1'b0, 1'b1, 3'd5, 4'd2);
        nops(4);
        expect_out("mode_hold", 1'b0, 1'b1, 3'd5, 4'd2);
        check_out();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
